// File: rtl/wb_pkg.sv
// Shared encodings for the MIPS write-back stage: write-back source selects and load sizes.
package wb_pkg;

   typedef logic [1:0] wb_sel_t;

   localparam wb_sel_t WB_SEL_ALU = 2'd0;
   localparam wb_sel_t WB_SEL_MEM = 2'd1;
   localparam wb_sel_t WB_SEL_PC8 = 2'd2;
   localparam wb_sel_t WB_SEL_IMM = 2'd3;

   localparam logic [1:0] LOAD_BYTE = 2'd0;
   localparam logic [1:0] LOAD_HALF = 2'd1;
   localparam logic [1:0] LOAD_WORD = 2'd2;

endpackage

// File: rtl/load_extract.sv
// Combinational load alignment: picks the addressed byte/halfword out of the raw load word and extends it.
module load_extract
   import wb_pkg::*;
#(
   parameter int BITS_SIZE = 32
) (
   input  logic [BITS_SIZE-1:0] i_mem_data,
   input  logic [1:0]           i_load_size,
   input  logic                 i_load_unsigned,
   input  logic [1:0]           i_addr_low,
   output logic [BITS_SIZE-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_byte_sign;
   logic        w_half_sign;

   assign w_byte      = i_mem_data[{i_addr_low, 3'b000} +: 8];
   // Only addr bit 1 matters for halfwords; misaligned accesses trap upstream.
   assign w_half      = i_addr_low[1] ? i_mem_data[31:16] : i_mem_data[15:0];
   assign w_byte_sign = ~i_load_unsigned & w_byte[7];
   assign w_half_sign = ~i_load_unsigned & w_half[15];

   always_comb begin
      o_data = i_mem_data;
      case (i_load_size)
         LOAD_BYTE: o_data = {{(BITS_SIZE-8){w_byte_sign}}, w_byte};
         LOAD_HALF: o_data = {{(BITS_SIZE-16){w_half_sign}}, w_half};
         default:   o_data = i_mem_data;
      endcase
   end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB stage register with write-back source select, link destination forcing and $zero suppression.
// Define WB_LOAD_ALIGN_EN to align and extend byte/halfword loads; otherwise the raw load word is written.
module wb_select_stage
   import wb_pkg::*;
#(
   parameter int BITS_SIZE     = 32,
   parameter int REG_ADDR_BITS = 5,
   parameter int LINK_REG      = 31
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_stall,
   input  logic                     i_flush,
   input  logic                     i_valid,
   input  logic [1:0]               i_wb_sel,
   input  logic                     i_link,
   input  logic                     i_reg_write,
   input  logic [REG_ADDR_BITS-1:0] i_rd,
   input  logic [BITS_SIZE-1:0]     i_alu_result,
   input  logic [BITS_SIZE-1:0]     i_mem_data,
   input  logic [BITS_SIZE-1:0]     i_pc8,
   input  logic [BITS_SIZE-1:0]     i_imm,
   input  logic [1:0]               i_load_size,
   input  logic                     i_load_unsigned,
   input  logic [1:0]               i_addr_low,
   output logic                     o_valid,
   output logic                     o_reg_write,
   output logic [REG_ADDR_BITS-1:0] o_rd,
   output logic [BITS_SIZE-1:0]     o_data_write
);

   logic [BITS_SIZE-1:0]     w_mem_value;
   logic [BITS_SIZE-1:0]     w_wb_data;
   logic [REG_ADDR_BITS-1:0] w_dest;
   logic                     w_reg_write;

   logic                     r_valid;
   logic                     r_reg_write;
   logic [REG_ADDR_BITS-1:0] r_rd;
   logic [BITS_SIZE-1:0]     r_data_write;

`ifdef WB_LOAD_ALIGN_EN
   load_extract #(
      .BITS_SIZE(BITS_SIZE)
   ) u_load_extract (
      .i_mem_data     (i_mem_data),
      .i_load_size    (i_load_size),
      .i_load_unsigned(i_load_unsigned),
      .i_addr_low     (i_addr_low),
      .o_data         (w_mem_value)
   );
`else
   logic w_unused_load_ctrl;
   assign w_unused_load_ctrl = ^{i_load_size, i_load_unsigned, i_addr_low};
   assign w_mem_value        = i_mem_data;
`endif

   always_comb begin
      w_wb_data = i_alu_result;
      case (wb_sel_t'(i_wb_sel))
         WB_SEL_ALU: w_wb_data = i_alu_result;
         WB_SEL_MEM: w_wb_data = w_mem_value;
         WB_SEL_PC8: w_wb_data = i_pc8;
         WB_SEL_IMM: w_wb_data = i_imm;
         default:    w_wb_data = i_alu_result;
      endcase
   end

   // Writes to $zero are dropped here so the regfile never sees them.
   assign w_dest      = i_link ? REG_ADDR_BITS'(LINK_REG) : i_rd;
   assign w_reg_write = i_valid & i_reg_write & (w_dest != '0);

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_valid      <= 1'b0;
         r_reg_write  <= 1'b0;
         r_rd         <= '0;
         r_data_write <= '0;
      end else if (!i_stall) begin
         r_valid      <= i_valid;
         r_reg_write  <= w_reg_write;
         r_rd         <= w_dest;
         r_data_write <= w_wb_data;
      end
   end

   assign o_valid      = r_valid;
   assign o_reg_write  = r_reg_write;
   assign o_rd         = r_rd;
   assign o_data_write = r_data_write;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: reference model feeds an expected queue, outputs checked after each edge.
module tb_wb_select_stage;

  localparam int W = 39;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid, link, reg_write, load_unsigned;
  logic [1:0]  wb_sel, load_size, addr_low;
  logic [4:0]  rd;
  logic [31:0] alu_result, mem_data, pc8, imm;
  logic        o_valid, o_reg_write;
  logic [4:0]  o_rd;
  logic [31:0] o_data_write;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  logic        m_valid = 1'b0, m_rw = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;

  always #5 clk = ~clk;

  wb_select_stage dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_wb_sel(wb_sel), .i_link(link), .i_reg_write(reg_write),
    .i_rd(rd), .i_alu_result(alu_result), .i_mem_data(mem_data), .i_pc8(pc8),
    .i_imm(imm), .i_load_size(load_size), .i_load_unsigned(load_unsigned),
    .i_addr_low(addr_low), .o_valid(o_valid), .o_reg_write(o_reg_write),
    .o_rd(o_rd), .o_data_write(o_data_write)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mem(input logic [31:0] d, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] al);
`ifdef WB_LOAD_ALIGN_EN
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * al));
    h = al[1] ? d[31:16] : d[15:0];
    if (sz == 2'd0) return uns ? {24'd0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) return uns ? {16'd0, h} : {{16{h[15]}}, h};
    return d;
`else
    return d;
`endif
  endfunction

  task automatic randomize_inputs();
    valid         = 1'($urandom_range(0, 1));
    wb_sel        = 2'($urandom_range(0, 3));
    link          = 1'($urandom_range(0, 1));
    reg_write     = 1'($urandom_range(0, 1));
    rd            = 5'($urandom_range(0, 31));
    alu_result    = $urandom;
    mem_data      = $urandom;
    pc8           = $urandom;
    imm           = $urandom;
    load_size     = 2'($urandom_range(0, 3));
    load_unsigned = 1'($urandom_range(0, 1));
    addr_low      = 2'($urandom_range(0, 3));
  endtask

  // Advance one clock: update the model from the current inputs, then compare DUT against the queue head.
  task automatic step();
    logic [W-1:0] e;
    logic [4:0]   dest;
    logic [31:0]  src;
    dest = link ? 5'd31 : rd;
    case (wb_sel)
      2'd0:    src = alu_result;
      2'd1:    src = model_mem(mem_data, load_size, load_unsigned, addr_low);
      2'd2:    src = pc8;
      default: src = imm;
    endcase
    if (reset || flush) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0;
    end else if (!stall) begin
      m_valid = valid;
      m_rw    = valid & reg_write & (dest != 5'd0);
      m_rd    = dest;
      m_data  = src;
    end
    exp_q.push_back({m_valid, m_rw, m_rd, m_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb_valid", 64'(o_valid), 64'(e[38]));
    check_eq("sb_reg_write", 64'(o_reg_write), 64'(e[37]));
    check_eq("sb_rd", 64'(o_rd), 64'(e[36:32]));
    check_eq("sb_data", 64'(o_data_write), 64'(e[31:0]));
  endtask

  task automatic capture_setup();
    reset = 0; stall = 0; flush = 0;
    randomize_inputs();
    valid = 1;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    randomize_inputs();

    // 1. reset with random inputs
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      stall = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      step();
      check_eq("reset_out", {o_valid, o_reg_write, o_rd, o_data_write}, 64'd0);
    end

    // 2. link write
    capture_setup();
    wb_sel = 2'd2; link = 1; rd = 5'd5; reg_write = 1; pc8 = 32'h0040_0010;
    step();
    check_eq("link_rd", 64'(o_rd), 64'd31);
    check_eq("link_data", 64'(o_data_write), 64'h0040_0010);
    check_eq("link_rw", 64'(o_reg_write), 64'd1);

`ifdef WB_LOAD_ALIGN_EN
    // 3. byte loads
    capture_setup();
    wb_sel = 2'd1; mem_data = 32'h80FF_7F01; load_size = 2'd0; addr_low = 2'd2; load_unsigned = 0;
    step();
    check_eq("lb_signed", 64'(o_data_write), 64'hFFFF_FFFF);
    addr_low = 2'd3; load_unsigned = 1;
    step();
    check_eq("lbu_top", 64'(o_data_write), 64'h0000_0080);
    load_size = 2'd1; addr_low = 2'd3; load_unsigned = 0;
    step();
    check_eq("lh_high", 64'(o_data_write), 64'hFFFF_80FF);
    addr_low = 2'd0; load_unsigned = 1;
    step();
    check_eq("lhu_low", 64'(o_data_write), 64'h0000_7F01);
`else
    // 6. raw load word passthrough
    capture_setup();
    wb_sel = 2'd1; mem_data = 32'hDEAD_BEEF; load_size = 2'd0; addr_low = 2'd1; load_unsigned = 0;
    step();
    check_eq("mem_raw", 64'(o_data_write), 64'hDEAD_BEEF);
`endif

    // 4. $zero write suppressed, data still captured
    capture_setup();
    wb_sel = 2'd0; link = 0; rd = 5'd0; reg_write = 1; alu_result = 32'hCAFE_0001;
    step();
    check_eq("zero_rw", 64'(o_reg_write), 64'd0);
    check_eq("zero_data", 64'(o_data_write), 64'hCAFE_0001);

    // 5. stall holds, flush wins over stall
    capture_setup();
    wb_sel = 2'd0; link = 0; rd = 5'd3; reg_write = 1; alu_result = 32'h0000_1234;
    step();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1;
      step();
      check_eq("stall_data", 64'(o_data_write), 64'h1234);
      check_eq("stall_rw", 64'(o_reg_write), 64'd1);
    end
    randomize_inputs();
    stall = 1; flush = 1;
    step();
    check_eq("flush_valid", 64'(o_valid), 64'd0);
    check_eq("flush_rw", 64'(o_reg_write), 64'd0);

    // Invalid instruction still captures rd/data but never writes
    capture_setup();
    valid = 0; reg_write = 1; link = 0; rd = 5'd9; wb_sel = 2'd3; imm = 32'h5555_AAAA;
    step();
    check_eq("inv_rw", 64'(o_reg_write), 64'd0);
    check_eq("inv_rd", 64'(o_rd), 64'd9);
    check_eq("inv_data", 64'(o_data_write), 64'h5555_AAAA);

    // Random traffic with occasional stall/flush/reset
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
